// File: rtl/mul_accum_pkg.sv
// mul_accum_pkg: shared types, defaults and sizing helper for the MAC accumulator stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mul_accum_pkg;

  localparam int DefDataWidth = 16;
  localparam int DefAccWidth  = 48;
  localparam int DefGroupLen  = 4;

  // ACC collects products; DONE holds a finished group total for downstream.
  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } accState_e;

  // Counter width for 0..groupLen-1; never narrower than one bit.
  function automatic int CntWidth(input int groupLen);
    return (groupLen <= 1) ? 1 : $clog2(groupLen);
  endfunction

endpackage

// File: rtl/mul_accum_if.sv
// mul_accum_if: product input handshake plus group-result output handshake.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry the flow control in each direction.
interface mul_accum_if
  import mul_accum_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int AccWidth  = DefAccWidth
) ();

  logic                   clr;
  logic                   in_valid;
  logic                   in_ready;
  logic [2*DataWidth:0]   in_prod;
  logic                   out_valid;
  logic                   out_ready;
  logic [AccWidth-1:0]    out_sum;
  logic                   out_ovf;

  // Upstream/downstream side: drives products and consumes results.
  modport master (
    output clr, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // Accumulator side.
  modport slave (
    input  clr, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/mul_accum_add.sv
// mul_accum_add: AccWidth-bit unsigned adder returning sum and carry-out.
// Latency: combinational. Saturates to all-ones on carry when MUL_ACCUM_SATURATE_EN is defined.
// Backpressure: not applicable.
module mul_accum_add #(
  parameter int AccWidth = 48
) (
  input  logic [AccWidth-1:0] accIn,
  input  logic [AccWidth-1:0] addend,
  output logic [AccWidth-1:0] sum,
  output logic                carry
);

  logic [AccWidth:0] fullSum;

  assign fullSum = {1'b0, accIn} + {1'b0, addend};
  assign carry   = fullSum[AccWidth];

`ifdef MUL_ACCUM_SATURATE_EN
  // Once a group has clamped, any further nonzero add carries again, so it stays clamped.
  assign sum = carry ? {AccWidth{1'b1}} : fullSum[AccWidth-1:0];
`else
  assign sum = fullSum[AccWidth-1:0];
`endif

endmodule

// File: rtl/mul_accum.sv
// mul_accum: sums GroupLen consecutive multiplier products into one registered group total.
// Latency: out_valid rises on the edge that accepts the group's last product; optional MUL_ACCUM_SATURATE_EN clamps on overflow.
// Backpressure: in_ready is low while a result waits in DONE; the result holds until out_ready.
module mul_accum
  import mul_accum_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int AccWidth  = DefAccWidth,
  parameter int GroupLen  = DefGroupLen
) (
  input  logic clk,
  input  logic rst_n,
  mul_accum_if.slave bus
);

  localparam int CntW = CntWidth(GroupLen);

  accState_e            state;
  accState_e            nextState;
  logic [AccWidth-1:0]  acc;
  logic [CntW-1:0]      cnt;
  logic                 ovf;
  logic [AccWidth-1:0]  outSum;
  logic                 outOvf;

  logic [2*DataWidth:0] prod;
  logic [AccWidth-1:0]  addend;
  logic [AccWidth-1:0]  addSum;
  logic                 addCarry;
  logic                 accept;
  logic                 lastProd;

  assign prod     = bus.in_prod;
  assign addend   = AccWidth'(prod);
  assign accept   = bus.in_valid && (state == ACC) && !bus.clr;
  assign lastProd = (cnt == CntW'(GroupLen - 1));

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = outSum;
  assign bus.out_ovf   = outOvf;

  mul_accum_add #(.AccWidth(AccWidth)) uAdd (
    .accIn  (acc),
    .addend (addend),
    .sum    (addSum),
    .carry  (addCarry)
  );

  // State register; reset and clr both return to ACC.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= nextState;
  end

  // Next state: finish a group on its last product, release it when downstream takes it.
  always_comb begin
    nextState = state;
    if (bus.clr) begin
      nextState = ACC;
    end else begin
      case (state)
        ACC:     if (accept && lastProd) nextState = DONE;
        DONE:    if (bus.out_ready)      nextState = ACC;
        default: nextState = ACC;
      endcase
    end
  end

  // Accumulate accepted products; on the last one publish the total and start a fresh group.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      outSum <= '0;
      outOvf <= 1'b0;
    end else if (accept) begin
      if (lastProd) begin
        outSum <= addSum;
        outOvf <= ovf | addCarry;
        acc    <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        acc    <= addSum;
        cnt    <= cnt + CntW'(1);
        ovf    <= ovf | addCarry;
      end
    end
  end

endmodule

// File: tb/tb_mul_accum.sv
// tb_mul_accum: drives three accumulator configurations against an exact-arithmetic group model.
// Latency: results expected on the edge accepting each group's last product.
// Backpressure: results must hold with in_ready low until out_ready is seen.
module tb_mul_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clrS;
  logic        inValid;
  logic        outReady;
  logic [32:0] inProd;
  int          sel;

  int total = 0;
  int bad   = 0;

  // Group model: exact running sum of the open group, count, and the pending result.
  logic [63:0] mExact;
  logic [63:0] mSum;
  logic        mOvf;
  logic        mPend;
  int          mCnt;
  int          curW;
  int          curG;

  logic        obsReady;
  logic        obsValid;
  logic [63:0] obsSum;
  logic        obsOvf;

  always #5 clk = ~clk;

  mul_accum_if #(.DataWidth(16), .AccWidth(48)) ifA ();
  mul_accum_if #(.DataWidth(16), .AccWidth(33)) ifB ();
  mul_accum_if #(.DataWidth(16), .AccWidth(48)) ifC ();

  assign ifA.clr       = clrS;
  assign ifA.in_valid  = inValid && (sel == 0);
  assign ifA.in_prod   = inProd;
  assign ifA.out_ready = outReady;
  assign ifB.clr       = clrS;
  assign ifB.in_valid  = inValid && (sel == 1);
  assign ifB.in_prod   = inProd;
  assign ifB.out_ready = outReady;
  assign ifC.clr       = clrS;
  assign ifC.in_valid  = inValid && (sel == 2);
  assign ifC.in_prod   = inProd;
  assign ifC.out_ready = outReady;

  mul_accum #(.DataWidth(16), .AccWidth(48), .GroupLen(4)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  mul_accum #(.DataWidth(16), .AccWidth(33), .GroupLen(2)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  mul_accum #(.DataWidth(16), .AccWidth(48), .GroupLen(1)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  // Observe the configuration under test.
  always_comb begin
    obsReady = ifA.in_ready;
    obsValid = ifA.out_valid;
    obsSum   = 64'(ifA.out_sum);
    obsOvf   = ifA.out_ovf;
    if (sel == 1) begin
      obsReady = ifB.in_ready;
      obsValid = ifB.out_valid;
      obsSum   = 64'(ifB.out_sum);
      obsOvf   = ifB.out_ovf;
    end else if (sel == 2) begin
      obsReady = ifC.in_ready;
      obsValid = ifC.out_valid;
      obsSum   = 64'(ifC.out_sum);
      obsOvf   = ifC.out_ovf;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] randProd();
    logic [63:0] r;
    r = 64'($urandom) | (64'($urandom_range(0, 1)) << 32);
    return r;
  endfunction

  // One clock: apply inputs, advance the model by the protocol rules, then compare.
  task automatic cyc(input logic v, input logic [63:0] p, input logic c, input logic r);
    logic [63:0] lim;
    inValid  = v;
    inProd   = p[32:0];
    clrS     = c;
    outReady = r;
    lim      = 64'd1 << curW;
    if (!rst_n || c) begin
      mExact = 0; mCnt = 0; mPend = 0; mSum = 0; mOvf = 0;
    end else if (mPend) begin
      if (r) mPend = 0;
    end else if (v) begin
      mExact = mExact + {31'b0, p[32:0]};
      mCnt++;
      if (mCnt == curG) begin
        mOvf = (mExact >= lim);
`ifdef MUL_ACCUM_SATURATE_EN
        mSum = mOvf ? (lim - 1) : mExact;
`else
        mSum = mExact & (lim - 1);
`endif
        mPend  = 1;
        mExact = 0;
        mCnt   = 0;
      end
    end
    @(posedge clk);
    #1;
    check("in_ready", {63'b0, obsReady}, {63'b0, !mPend});
    check("out_valid", {63'b0, obsValid}, {63'b0, mPend});
    if (mPend || !rst_n) begin
      check("out_sum", obsSum, mSum);
      check("out_ovf", {63'b0, obsOvf}, {63'b0, mOvf});
    end
  endtask

  task automatic startPhase(input int s, input int w, input int g);
    sel   = s;
    curW  = w;
    curG  = g;
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic randomRun(input int n);
    for (int i = 0; i < n; i++)
      cyc(($urandom % 3) != 0, randProd(), ($urandom % 40) == 0, $urandom % 2);
  endtask

  initial begin
    sel = 0; rst_n = 1'b0; clrS = 0; inValid = 0; outReady = 0; inProd = '0;
    mExact = 0; mSum = 0; mOvf = 0; mPend = 0; mCnt = 0; curW = 48; curG = 4;

    // GroupLen=4, AccWidth=48: products of a=2k, b=5k.
    startPhase(0, 48, 4);
    cyc(1, 10, 0, 0); cyc(1, 40, 0, 0); cyc(1, 90, 0, 0); cyc(1, 160, 0, 0);
    check("normal_sum", obsSum, 64'd300);
    check("normal_valid", {63'b0, obsValid}, 64'd1);

    // Result held under backpressure while products are offered.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 64'($urandom), 0, 0);
      check("bp_stable", obsSum, 64'd300);
    end
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    check("fresh_sum", obsSum, 64'd10);
    cyc(0, 0, 0, 1);

    // Gaps between products leave the group untouched.
    cyc(1, 5, 0, 0); cyc(0, 999, 0, 0); cyc(0, 0, 0, 1); cyc(1, 6, 0, 0);
    cyc(0, 77, 0, 0); cyc(1, 7, 0, 0); cyc(1, 8, 0, 0);
    check("gap_sum", obsSum, 64'd26);
    cyc(0, 0, 0, 1);

    // clr with a concurrent product drops the partial group and the product.
    cyc(1, 100, 0, 0); cyc(1, 200, 0, 0); cyc(1, 300, 1, 0);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    check("clr_sum", obsSum, 64'd10);
    cyc(0, 0, 0, 1);

    // Reset after three products, then a clean group.
    cyc(1, 11, 0, 0); cyc(1, 11, 0, 0); cyc(1, 11, 0, 0);
    rst_n = 1'b0; cyc(1, 50, 0, 0); rst_n = 1'b1;
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    check("rst_mid_sum", obsSum, 64'd10);

    // Reset while a result is pending.
    rst_n = 1'b0; cyc(0, 0, 0, 0); rst_n = 1'b1;
    check("rst_done_valid", {63'b0, obsValid}, 64'd0);
    cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0);
    check("rst_done_sum", obsSum, 64'd20);
    cyc(0, 0, 0, 1);
    randomRun(300);

    // AccWidth=33, GroupLen=2: two 2^32 products carry out.
    startPhase(1, 33, 2);
    cyc(1, 64'd1 << 32, 0, 0); cyc(1, 64'd1 << 32, 0, 0);
`ifdef MUL_ACCUM_SATURATE_EN
    check("ovf_sum", obsSum, (64'd1 << 33) - 1);
`else
    check("ovf_sum", obsSum, 64'd0);
`endif
    check("ovf_flag", {63'b0, obsOvf}, 64'd1);
    cyc(0, 0, 0, 1);
    randomRun(200);

    // GroupLen=1: each accepted product is its own result.
    startPhase(2, 48, 1);
    cyc(1, 7, 0, 0);
    check("g1_first", obsSum, 64'd7);
    cyc(0, 0, 0, 1);
    cyc(1, 9, 0, 0);
    check("g1_second", obsSum, 64'd9);
    cyc(0, 0, 0, 1);
    randomRun(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
